// File: rtl/mdu_pkg.sv
// Shared MDU opcodes, FSM encodings and helpers.
// Opcodes 9-12 are only decoded when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_t;

  function automatic int max_i(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mod_mdu_timer.sv
// Loadable down-counter for MDU latency.
// o_done is high whenever the count has reached zero.
module mod_mdu_timer #(
  parameter int CW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_val,
  input  logic          i_en,
  output logic          o_done
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/mod_mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu.
module mod_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iStart,
  input  logic [3:0]       iMDUOp,
  input  logic [WIDTH-1:0] iNumber1,
  input  logic [WIDTH-1:0] iNumber2,
  output logic             oBusy,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO,
  output logic [WIDTH-1:0] oResult
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(max_i(MULT_CYCLES, DIV_CYCLES) + 1);

  state_t           r_state;
  logic             r_busy;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [W2-1:0]    r_pend;
  logic             r_div0;

  logic             w_mul;
  logic             w_div;
  logic             w_sgn;
  logic             w_load;
  logic [CW-1:0]    w_load_val;
  logic             w_done;
  logic [W2-1:0]    w_ea;
  logic [W2-1:0]    w_eb;
  logic [W2-1:0]    w_prod;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_dvsr;
  logic [WIDTH-1:0] w_uq;
  logic [WIDTH-1:0] w_ur;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  logic [W2-1:0]    w_final;

`ifdef MDU_MADD_EN
  acc_t             r_acc;
  acc_t             w_acc;
  logic [W2-1:0]    w_hilo;
`endif

  always_comb begin
    w_mul = 1'b0;
    w_div = 1'b0;
    w_sgn = 1'b0;
`ifdef MDU_MADD_EN
    w_acc = ACC_NONE;
`endif
    unique case (1'b1)
      (iMDUOp == OP_MULT):  begin w_mul = 1'b1; w_sgn = 1'b1; end
      (iMDUOp == OP_MULTU): w_mul = 1'b1;
      (iMDUOp == OP_DIV):   begin w_div = 1'b1; w_sgn = 1'b1; end
      (iMDUOp == OP_DIVU):  w_div = 1'b1;
`ifdef MDU_MADD_EN
      (iMDUOp == OP_MADD):  begin w_mul = 1'b1; w_sgn = 1'b1; w_acc = ACC_ADD; end
      (iMDUOp == OP_MADDU): begin w_mul = 1'b1; w_acc = ACC_ADD; end
      (iMDUOp == OP_MSUB):  begin w_mul = 1'b1; w_sgn = 1'b1; w_acc = ACC_SUB; end
      (iMDUOp == OP_MSUBU): begin w_mul = 1'b1; w_acc = ACC_SUB; end
`endif
      default: ;
    endcase
  end

  // Sign-extending to 2W lets one unsigned multiply serve both variants
  assign w_ea   = w_sgn ? {{WIDTH{iNumber1[WIDTH-1]}}, iNumber1}
                        : {{WIDTH{1'b0}}, iNumber1};
  assign w_eb   = w_sgn ? {{WIDTH{iNumber2[WIDTH-1]}}, iNumber2}
                        : {{WIDTH{1'b0}}, iNumber2};
  assign w_prod = w_ea * w_eb;

  assign w_neg_a = w_sgn & iNumber1[WIDTH-1];
  assign w_neg_b = w_sgn & iNumber2[WIDTH-1];
  assign w_mag_a = w_neg_a ? -iNumber1 : iNumber1;
  assign w_mag_b = w_neg_b ? -iNumber2 : iNumber2;
  assign w_dvsr  = (w_mag_b == '0) ? WIDTH'(1) : w_mag_b;
  assign w_uq    = w_mag_a / w_dvsr;
  assign w_ur    = w_mag_a % w_dvsr;
  assign w_q     = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
  assign w_r     = w_neg_a ? -w_ur : w_ur;

`ifdef MDU_MADD_EN
  assign w_hilo = {r_hi, r_lo};
  always_comb begin
    w_final = r_pend;
    unique case (r_acc)
      ACC_ADD: w_final = w_hilo + r_pend;
      ACC_SUB: w_final = w_hilo - r_pend;
      default: w_final = r_pend;
    endcase
  end
`else
  assign w_final = r_pend;
`endif

  assign w_load     = (r_state == ST_IDLE) & iStart & (w_mul | w_div);
  assign w_load_val = w_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);

  mod_mdu_timer #(
    .CW(CW)
  ) u_timer (
    .i_clk  (iClk),
    .i_rst  (iReset),
    .i_load (w_load),
    .i_val  (w_load_val),
    .i_en   (r_busy),
    .o_done (w_done)
  );

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_pend  <= '0;
      r_div0  <= 1'b0;
`ifdef MDU_MADD_EN
      r_acc   <= ACC_NONE;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (iStart) begin
            if (w_mul) begin
              r_pend  <= w_prod;
              r_state <= ST_MULT;
              r_busy  <= 1'b1;
`ifdef MDU_MADD_EN
              r_acc   <= w_acc;
`endif
            end else if (w_div) begin
              r_pend  <= {w_r, w_q};
              r_div0  <= (iNumber2 == '0);
              r_state <= ST_DIV;
              r_busy  <= 1'b1;
`ifdef MDU_MADD_EN
              r_acc   <= ACC_NONE;
`endif
            end else if (iMDUOp == OP_MTHI) begin
              r_hi <= iNumber1;
            end else if (iMDUOp == OP_MTLO) begin
              r_lo <= iNumber1;
            end
          end
        end
        ST_MULT, ST_DIV: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (!((r_state == ST_DIV) && r_div0)) begin
              {r_hi, r_lo} <= w_final;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    oResult = '0;
    if (iMDUOp == OP_MFHI) begin
      oResult = r_hi;
    end else if (iMDUOp == OP_MFLO) begin
      oResult = r_lo;
    end
  end

  assign oBusy = r_busy;
  assign oHI   = r_hi;
  assign oLO   = r_lo;

endmodule

// File: doc/mod_mdu.md
Name: mod_mdu

Overview:
- Parametrised multiply/divide unit; next generation of the execute-stage arithmetic block.
- Sits in EX beside the ALU.
- Owns the HI/LO registers. Runs multi-cycle mult/div operations and raises a busy flag so the hazard unit stalls later HI/LO users.
- Serves mfhi/mflo reads and mthi/mtlo writes.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- iClk  input  1  clock, rising edge.
- iReset  input  1  synchronous, active-high reset.
- iStart  input  1  issue strobe for the op on iMDUOp; sampled on the rising edge.
- iMDUOp  input  4  operation code (see Decomposition).
- iNumber1  input  WIDTH  rs operand.
- iNumber2  input  WIDTH  rt operand.
- oBusy  output  1  high while a mult/div is in flight.
- oHI  output  WIDTH  current HI register.
- oLO  output  WIDTH  current LO register.
- oResult  output  WIDTH  HI when iMDUOp==mfhi, LO when iMDUOp==mflo, else 0; combinational from registers.

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, oBusy=0, state=IDLE, counter=0, pending result=0. A reset during MULT/DIV aborts the operation; HI/LO are not written.
- State machine: IDLE, MULT, DIV.
- IDLE, iStart with mult/multu:
  - Latch the full 2*WIDTH product (signed/unsigned per op) into a pending register.
  - Load counter=MULT_CYCLES-1; go to MULT.
- IDLE, iStart with div/divu:
  - Latch quotient and remainder into the pending register.
  - Load counter=DIV_CYCLES-1; go to DIV.
- IDLE, iStart with mthi/mtlo: write iNumber1 to HI/LO at that edge; stay IDLE; oBusy stays 0.
- mfhi/mflo never need iStart; they are pure reads.
- MULT/DIV:
  - oBusy=1 throughout; counter decrements each cycle.
  - When counter==0, on that edge: HI/LO <= pending, state<=IDLE, oBusy<=0.
  - Latency: oBusy is high for exactly N cycles after the issue edge; new HI/LO are visible in the first cycle with oBusy=0.
- iStart while oBusy=1 is ignored for every op, including mthi/mtlo. HI/LO and the timer are unaffected. The pipeline must stall instead.
- Product rules:
  - mult: signed WIDTH x WIDTH, HI=upper WIDTH bits, LO=lower WIDTH bits.
  - multu: same, unsigned.
- Divide rules:
  - LO=quotient, HI=remainder.
  - div: signed, quotient truncates toward zero, remainder takes the dividend's sign.
  - div of INT_MIN by -1: LO=INT_MIN, HI=0.
  - Divisor==0: still busy DIV_CYCLES cycles; HI/LO unchanged at completion.
- oResult/oHI/oLO during busy show the old HI/LO (not the pending value).
- Unknown iMDUOp with iStart: no effect.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: adds madd/maddu/msub/msubu opcodes, each MULT_CYCLES latency.
  - At completion {HI,LO} <= {HI,LO} ± product, using the HI/LO values present at completion, modulo 2^(2*WIDTH).
- Undefined: these opcodes decode as unknown (no effect, no busy).

Decomposition:
- Package mdu_pkg:
  - MDU op codes: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu.
  - State encodings IDLE=0, MULT=1, DIV=2.
- One sub-module, mod_mdu_timer: loadable down-counter with done pulse at zero.

Test Plan:
- Reset mid-op: issue mult, assert iReset on cycle 2 → oBusy=0 next cycle, HI=LO=0.
- mult and multu: mult 0xFFFFFFFF × 0x00000002 → oBusy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands → HI=0x00000001, LO=0xFFFFFFFE.
- Signed div cases:
  - div -7 / 2 → busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - divu 7 / 2 → LO=3, HI=1.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: mthi 0x11, mtlo 0x22, then div 5/0 → after 10 busy cycles HI=0x11, LO=0x22.
- Issue while busy: mtlo 0xAB during a busy mult → ignored. mult result lands; mflo then returns the product's low word, and oResult during busy shows the old LO.
- MDU_MADD_EN build: HI=0, LO=0xFFFFFFFF, then maddu 1×1 → HI=1, LO=0 after 5 cycles.
